// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window feeder.
// Optional feature macro: CONV_FEEDER_ZERO_PAD_EN (adds the FLUSH state).
package conv_pkg;

   localparam int DW_DEF   = 6;
   localparam int TAPS_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
`ifdef CONV_FEEDER_ZERO_PAD_EN
      ,
      FLUSH  = 2'd3
`endif
   } feed_state_e;

   // Resting state implied by a window fill count.
   function automatic feed_state_e state_for_count(input int cnt, input int taps);
      if (cnt == 0) return IDLE;
      if (cnt >= taps) return STREAM;
      return FILL;
   endfunction

endpackage

// File: rtl/conv_shift_reg.sv
// DW x TAPS shift register: newest entry enters at the top DW bits,
// the oldest falls out of [DW-1:0].
module conv_shift_reg
   import conv_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int TAPS = TAPS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               ld_en,
   input  logic [DW-1:0]      din,
   output logic [TAPS*DW-1:0] q
);

   // Shift one entry in from the top on load; clear or reset empties it.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         q <= '0;
      end else if (ld_en) begin
         q <= {din, q[TAPS*DW-1:DW]};
      end
   end

endmodule

// File: rtl/conv_window_feeder.sv
// Sliding-window feeder for a convolution MAC: collects samples into a
// TAPS-long window, keeps a separate weight register, and presents each
// full window over a valid/ready handshake.
// Optional feature macro: CONV_FEEDER_ZERO_PAD_EN (zero-pad flush after in_last).
//
// state  | meaning
// IDLE   | window empty for this frame (count 0)
// FILL   | partial window, 0 < count < TAPS
// STREAM | full window, every new sample produces a window
// FLUSH  | shifting TAPS-1 trailing zeros after in_last (zero-pad build only)
module conv_window_feeder
   import conv_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int TAPS = TAPS_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DW-1:0]      in_data,
   input  logic               in_is_weight,
   input  logic               in_last,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [TAPS*DW-1:0] win_data,
   output logic [TAPS*DW-1:0] win_weights,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last
);

   localparam int CW = $clog2(TAPS + 1);
   localparam logic [CW-1:0] FULL = CW'(TAPS);

   feed_state_e   state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          run;
   logic          slot_free;
   logic          flush_busy;
   logic          flush_step;
   logic          acc_s;
   logic          acc_w;
   logic          win_ld;
   logic [DW-1:0] win_din;

`ifdef CONV_FEEDER_ZERO_PAD_EN
   logic [CW-1:0] flush_left;
   assign flush_busy = (state == FLUSH);
`else
   assign flush_busy = 1'b0;
`endif

   // run holds in_ready low through reset and releases it one edge later.
   assign slot_free = !out_valid || out_ready;
   assign in_ready  = run && !flush_busy && (in_is_weight ? !out_valid : slot_free);
   assign acc_s     = in_valid && in_ready && !in_is_weight;
   assign acc_w     = in_valid && in_ready && in_is_weight;
   assign flush_step = flush_busy && slot_free;
   assign win_ld    = acc_s || flush_step;
   assign win_din   = acc_s ? in_data : '0;
   assign cnt_inc   = (state == STREAM || cnt == FULL) ? FULL : cnt + CW'(1);

   conv_shift_reg #(.DW(DW), .TAPS(TAPS)) u_window (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .ld_en (win_ld),
      .din   (win_din),
      .q     (win_data)
   );

   // Weights only load while no window is presented, so they stay frozen
   // for the whole life of a pending window.
   conv_shift_reg #(.DW(DW), .TAPS(TAPS)) u_weights (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .ld_en (acc_w),
      .din   (in_data),
      .q     (win_weights)
   );

   // Fill-count FSM with registered window handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         run       <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
`ifdef CONV_FEEDER_ZERO_PAD_EN
         flush_left <= '0;
`endif
      end else begin
         run <= 1'b1;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (acc_s) begin
            if (cnt_inc == FULL) begin
               out_valid <= 1'b1;
`ifdef CONV_FEEDER_ZERO_PAD_EN
               out_last  <= 1'b0;
`else
               out_last  <= in_last;
`endif
            end
            if (in_last) begin
`ifdef CONV_FEEDER_ZERO_PAD_EN
               cnt        <= cnt_inc;
               state      <= FLUSH;
               flush_left <= CW'(TAPS - 1);
`else
               cnt   <= '0;
               state <= IDLE;
`endif
            end else begin
               cnt   <= cnt_inc;
               state <= state_for_count(int'(cnt_inc), TAPS);
            end
         end
`ifdef CONV_FEEDER_ZERO_PAD_EN
         else if (flush_step) begin
            if (cnt_inc == FULL) begin
               out_valid <= 1'b1;
               out_last  <= (flush_left == CW'(1));
            end
            if (flush_left == CW'(1)) begin
               cnt        <= '0;
               state      <= IDLE;
               flush_left <= '0;
            end else begin
               cnt        <= cnt_inc;
               flush_left <= flush_left - CW'(1);
            end
         end
`endif
      end
   end

endmodule
